// File: rtl/iir_lp_channel_scheduler_pkg.sv
// Shared types for the multi-channel IIR low-pass scheduler.
// FSM state encoding and small index helpers.
package iir_lp_channel_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int wrap_inc(int v, int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/iir_lp_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first requester at or above ptr, wrapping.
module rr_arbiter
  import iir_lp_channel_scheduler_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     ptr,
  output logic [CHANNELS-1:0] gnt,
  output logic [CH_W-1:0]     idx
);

  int   c;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    c     = 0;
    found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      c = (int'(ptr) + i) % CHANNELS;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/iir_lp_channel_scheduler.sv
// Time-shared single-pole IIR low-pass over CHANNELS streams.
// One shared datapath, per-channel accumulator bank, RR input arbitration.
module iir_lp_channel_scheduler
  import iir_lp_channel_scheduler_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 16,
  parameter  int GAIN     = 8,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH_W-1:0]           out_chan,
  output logic signed [WIDTH-1:0]   out_data
);

  localparam int ACC_W = WIDTH + GAIN;

  state_t state, state_d;

  logic [CH_W-1:0]         rr_ptr;
  logic [CH_W-1:0]         gidx;
  logic [CH_W-1:0]         chan_q;
  logic [CHANNELS-1:0]     gnt;
  logic signed [WIDTH-1:0] x_q;
  logic                    take;

  logic signed [ACC_W-1:0] acc [CHANNELS];
  logic signed [ACC_W-1:0] acc_cur;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] x_ext;

  rr_arbiter #(
    .CHANNELS(CHANNELS)
  ) u_arb (
    .req(in_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gidx)
  );

  // Grants only while idle, enabled and out of reset
  assign in_ready = (state == IDLE && en && rst) ? gnt : '0;
  assign take     = |(in_valid & in_ready);

  assign x_ext   = $signed({{GAIN{x_q[WIDTH-1]}}, x_q});
  assign acc_cur = acc[chan_q];
  assign acc_nxt = acc_cur + x_ext - (acc_cur >>> GAIN);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (take) state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      x_q       <= '0;
      chan_q    <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
    end else begin
      state <= state_d;
      if (take) begin
        x_q    <= in_data[gidx*WIDTH +: WIDTH];
        chan_q <= gidx;
        rr_ptr <= CH_W'(wrap_inc(int'(gidx), CHANNELS));
      end
      if (state == CALC) begin
        out_valid <= 1'b1;
        out_data  <= acc_nxt[WIDTH+GAIN-1:GAIN];
        out_chan  <= chan_q;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Clear has priority over a same-cycle filter update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (clr[c]) begin
          acc[c] <= '0;
        end else if (state == CALC && chan_q == CH_W'(c)) begin
          acc[c] <= acc_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_lp_channel_scheduler.sv
// Directed scoreboard bench for iir_lp_channel_scheduler.
// Expected outputs come from a per-channel integer filter model.
module tb_iir_lp_channel_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  clr;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;
  logic signed [15:0] out_data;

  iir_lp_channel_scheduler #(
    .CHANNELS(4),
    .WIDTH(16),
    .GAIN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clr(clr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_chan(out_chan),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int y;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   macc [4];
  exp_t q [$];
  int   gq [$];
  int   tq [$];
  int   out_cnt = 0;
  int   acc_cnt = 0;
  int   cyc = 0;
  int   last_data = 0;
  int   last_chan = 0;

  task automatic chk(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(int c, int x);
    int a;
    a = macc[c] + x - (macc[c] >>> 8);
    macc[c] = a;
    return a >>> 8;
  endfunction

  task automatic set_data(int c, int x);
    in_data[c*16 +: 16] = 16'(x);
  endtask

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < 4; c++) macc[c] = 0;
  endtask

  // Observe on the falling edge, then advance past the rising edge
  task automatic step();
    logic signed [15:0] xs;
    exp_t e;
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 4; c++) if (clr[c]) macc[c] = 0;
    chk("in_ready_onehot", int'($onehot0(in_ready)), 1);
    for (int c = 0; c < 4; c++) begin
      if (in_valid[c] && in_ready[c]) begin
        xs = in_data[c*16 +: 16];
        e.ch = c;
        e.y  = model(c, int'(xs));
        q.push_back(e);
        gq.push_back(c);
        acc_cnt++;
      end
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("out_chan", int'(out_chan), e.ch);
        chk("out_data", int'(out_data), e.y);
      end
      last_data = int'(out_data);
      last_chan = int'(out_chan);
      tq.push_back(cyc);
      out_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(int n, int budget, string tag);
    int start;
    int k;
    start = out_cnt;
    k = 0;
    while (out_cnt < start + n && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_timeout"}, int'(out_cnt >= start + n), 1);
  endtask

  task automatic wait_acc(int budget, string tag);
    int start;
    int k;
    start = acc_cnt;
    k = 0;
    while (acc_cnt == start && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_accept_timeout"}, int'(acc_cnt > start), 1);
  endtask

  task automatic feed(int c, int x, int n, string tag);
    set_data(c, x);
    in_valid = 4'b0;
    in_valid[c] = 1'b1;
    wait_out(n, 4 * n + 10, tag);
    in_valid = 4'b0;
  endtask

  int snap_d;
  int snap_c;
  int k;

  initial begin
    rst = 1'b0;
    en = 1'b1;
    clr = 4'b0;
    in_valid = 4'b1111;
    in_data = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_chan", int'(out_chan), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    in_valid = 4'b0;
    rst = 1'b1;
    step();

    // Step response on channel 0
    feed(0, 16384, 1, "step1");
    chk("step_first", last_data, 64);
    feed(0, 16384, 1, "step2");
    chk("step_second", last_data, 127);
    feed(0, 16384, 6, "step_more");
    chk("step_chan", last_chan, 0);
    chk("step_rising", int'(last_data > 127), 1);

    // Negative full-scale on a fresh channel
    feed(2, -32768, 1, "neg");
    chk("neg_first", last_data, -128);
    feed(0, 16384, 1, "ch0_untouched");

    // Round-robin from a fresh reset
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_data(0, 1000);
    set_data(1, 2000);
    set_data(2, -3000);
    set_data(3, 4000);
    gq.delete();
    tq.delete();
    in_valid = 4'b1111;
    wait_out(8, 40, "rr");
    in_valid = 4'b0;
    for (int i = 0; i < 8; i++) begin
      chk("rr_order", (i < gq.size()) ? gq[i] : -1, i % 4);
    end
    for (int i = 1; i < 8; i++) begin
      chk("rr_period", (i < tq.size()) ? tq[i] - tq[i-1] : -1, 3);
    end

    // Backpressure holds the output stable
    set_data(1, 5000);
    in_valid = 4'b0010;
    out_ready = 1'b0;
    wait_acc(10, "bp");
    in_valid = 4'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      step();
      k++;
    end
    chk("bp_valid_seen", int'(out_valid), 1);
    snap_d = int'(out_data);
    snap_c = int'(out_chan);
    in_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), snap_d);
      chk("bp_chan", int'(out_chan), snap_c);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 4'b0;
    out_ready = 1'b1;
    wait_out(1, 5, "bp_release");
    chk("bp_release_chan", last_chan, 1);

    // Clear while idle, then clear coincident with CALC
    feed(1, 10000, 2, "clr_prep");
    chk("clr_prep_nonzero", int'(last_data != 0), 1);
    clr = 4'b0010;
    step();
    clr = 4'b0;
    feed(1, 256, 1, "clr_idle");
    chk("clr_idle_out", last_data, 1);
    set_data(1, 3000);
    in_valid = 4'b0010;
    wait_acc(10, "clr_calc");
    in_valid = 4'b0;
    clr = 4'b0010;
    step();
    clr = 4'b0;
    wait_out(1, 5, "clr_calc_out");
    feed(1, 256, 1, "clr_calc_after");
    chk("clr_calc_acc0", last_data, 1);

    // Reset during CALC discards the in-flight sample
    set_data(0, 16384);
    in_valid = 4'b0001;
    wait_acc(10, "rst_mid");
    in_valid = 4'b0;
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", int'(out_valid), 0);
    model_reset();
    step();
    chk("rst_mid_hold", int'(out_valid), 0);
    rst = 1'b1;
    en = 1'b0;
    in_valid = 4'b1111;
    k = out_cnt;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en0_in_ready", int'(in_ready), 0);
    end
    chk("en0_no_out", out_cnt, k);
    en = 1'b1;
    #1;
    chk("rst_ptr0", int'(in_ready), 1);
    in_valid = 4'b0001;
    wait_out(1, 6, "rst_after");
    in_valid = 4'b0;
    chk("rst_acc0", last_data, 64);
    chk("rst_after_chan", last_chan, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
